// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtractor built around one full-subtractor
// cell and a borrow flip-flop. Operands are latched on an accepted start.
// They are then consumed LSB-first, one bit per clock. The result diff = a - b
// (mod 2^WIDTH) and the final borrow are presented with a one-cycle done pulse.
// Optional feature: define SERIAL_SUB_ZERO_EN to add a registered 'zero' flag
// that reports diff == 0.
module serial_sub_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_ZERO_EN
    ,
    output logic             zero
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic             bff;

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] sr_next;
    logic             last_bit;

`ifdef SERIAL_SUB_ZERO_EN
    logic             any_one;
`endif

    // One-bit full-subtractor slice: returns {borrow_out, difference}
    function automatic logic [1:0] sub_cell(input logic x, input logic y, input logic bin);
        logic d;
        logic bout;
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
        return {bout, d};
    endfunction

    // Cell evaluation for the current LSBs and the result register's next value
    always_comb begin
        {cell_bout, cell_d} = sub_cell(sa[0], sb[0], bff);
        sr_next             = {cell_d, sr[WIDTH-1:1]};
        last_bit            = (cnt == CNT_W'(WIDTH - 1));
    end

    assign busy = (state != IDLE);

    // Control FSM: IDLE -> SHIFT (WIDTH edges) -> DONE (one cycle) -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= SHIFT;
                SHIFT:   if (last_bit) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand shift registers, result shift register, borrow FF and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa  <= '0;
            sb  <= '0;
            sr  <= '0;
            bff <= 1'b0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        sr  <= '0;
                        bff <= 1'b0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= sr_next;
                    bff <= cell_bout;
                    // Counter stops on the final bit instead of wrapping
                    if (!last_bit) cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Result outputs: only written when the last bit is processed, held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            done <= (state == SHIFT) && last_bit;
            if ((state == SHIFT) && last_bit) begin
                diff       <= sr_next;
                borrow_out <= cell_bout;
            end
        end
    end

`ifdef SERIAL_SUB_ZERO_EN
    // Sticky OR of difference bits; zero flag published alongside diff
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_one <= 1'b0;
            zero    <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                any_one <= 1'b0;
            end else if (state == SHIFT) begin
                any_one <= any_one | cell_d;
                if (last_bit) zero <= ~(any_one | cell_d);
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed testbench for serial_sub_ctrl (WIDTH = 8).
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_ZERO_EN
    logic         zero;
`endif

    int checks = 0;
    int errors = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_ZERO_EN
        ,
        .zero       (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation from IDLE (called at a negedge) and wait for done.
    // lat = number of edges after the accept edge until done is seen (-1 on timeout).
    // bcnt = number of sampled cycles with busy high, from the accept edge through done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          output int lat, output int bcnt,
                          output logic [W-1:0] rd, output logic rb, output logic rz);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        lat   = -1;
        bcnt  = 0;
        @(posedge clk);
        #1 start = 1'b0;
        a = ~ta;
        b = ~tb_v;
        @(negedge clk);
        if (busy) bcnt++;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
        rd = diff;
        rb = borrow_out;
`ifdef SERIAL_SUB_ZERO_EN
        rz = zero;
`else
        rz = 1'b0;
`endif
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b diff=%h borrow=%b, required 0 0 00 0",
                     busy, done, diff, borrow_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, bcnt;
        logic [W-1:0] rd;
        logic rb, rz;
        run_op(8'h5A, 8'h25, lat, bcnt, rd, rb, rz);
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL basic_latency: edges=%0d required %0d", lat, W);
        end
        checks++;
        if (rd !== 8'h35 || rb !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: diff=%h borrow=%b required 35 0", rd, rb);
        end
        checks++;
        if (bcnt !== W + 1) begin
            errors++;
            $display("FAIL basic_busy_cycles: %0d required %0d", bcnt, W + 1);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_done: done=%b busy=%b required 0 0", done, busy);
        end
        checks++;
        if (diff !== 8'h35) begin
            errors++;
            $display("FAIL basic_hold: diff=%h required 35", diff);
        end
    endtask

    task automatic test_borrow;
        int lat, bcnt;
        logic [W-1:0] rd;
        logic rb, rz;
        run_op(8'h00, 8'h01, lat, bcnt, rd, rb, rz);
        checks++;
        if (lat !== W || rd !== 8'hFF || rb !== 1'b1) begin
            errors++;
            $display("FAIL borrow_underflow: lat=%0d diff=%h borrow=%b required %0d ff 1", lat, rd, rb, W);
        end
        @(negedge clk);
        run_op(8'h80, 8'h7F, lat, bcnt, rd, rb, rz);
        checks++;
        if (lat !== W || rd !== 8'h01 || rb !== 1'b0) begin
            errors++;
            $display("FAIL borrow_msb: lat=%0d diff=%h borrow=%b required %0d 01 0", lat, rd, rb, W);
        end
        @(negedge clk);
    endtask

    task automatic test_zero;
        int lat, bcnt;
        logic [W-1:0] rd;
        logic rb, rz;
        run_op(8'hFF, 8'hFF, lat, bcnt, rd, rb, rz);
        checks++;
        if (lat !== W || rd !== 8'h00 || rb !== 1'b0) begin
            errors++;
            $display("FAIL zero_equal: lat=%0d diff=%h borrow=%b required %0d 00 0", lat, rd, rb, W);
        end
`ifdef SERIAL_SUB_ZERO_EN
        checks++;
        if (rz !== 1'b1) begin
            errors++;
            $display("FAIL zero_flag_set: zero=%b required 1", rz);
        end
`endif
        @(negedge clk);
        run_op(8'h03, 8'h01, lat, bcnt, rd, rb, rz);
        checks++;
        if (lat !== W || rd !== 8'h02 || rb !== 1'b0) begin
            errors++;
            $display("FAIL zero_nonzero: lat=%0d diff=%h borrow=%b required %0d 02 0", lat, rd, rb, W);
        end
`ifdef SERIAL_SUB_ZERO_EN
        checks++;
        if (rz !== 1'b0) begin
            errors++;
            $display("FAIL zero_flag_clear: zero=%b required 0", rz);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int lat;
        int extra_done;
        int extra_busy;
        a     = 8'h10;
        b     = 8'h01;
        start = 1'b1;
        lat   = -1;
        @(posedge clk);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            a     = 8'(n * 37);
            b     = 8'(n * 11 + 3);
            start = n[0];
            if (done) begin
                lat = n - 1;
                break;
            end
            @(posedge clk);
        end
        // Hold start high through the DONE cycle so the DONE->IDLE edge sees it
        start = 1'b1;
        checks++;
        if (lat !== W || diff !== 8'h0F || borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: lat=%0d diff=%h borrow=%b required %0d 0f 0",
                     lat, diff, borrow_out, W);
        end
        @(posedge clk);
        #1 start = 1'b0;
        extra_done = 0;
        extra_busy = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
            @(posedge clk);
        end
        checks++;
        if (extra_done !== 0 || extra_busy !== 0) begin
            errors++;
            $display("FAIL ignore_no_second_op: done_cycles=%0d busy_cycles=%0d required 0 0",
                     extra_done, extra_busy);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        int lat, bcnt;
        logic [W-1:0] rd;
        logic rb, rz;
        a     = 8'hC3;
        b     = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b diff=%h borrow=%b required 0 0 00 0",
                     busy, done, diff, borrow_out);
        end
`ifdef SERIAL_SUB_ZERO_EN
        checks++;
        if (zero !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_zero: zero=%b required 0", zero);
        end
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_idle: busy=%b done=%b required 0 0", busy, done);
        end
        run_op(8'h09, 8'h04, lat, bcnt, rd, rb, rz);
        checks++;
        if (lat !== W || rd !== 8'h05 || rb !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_recover: lat=%0d diff=%h borrow=%b required %0d 05 0",
                     lat, rd, rb, W);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic exp_done;
        logic prev_done;
        int   bad_done;
        int   bad_diff;
        int   ndone;
        a         = 8'h20;
        b         = 8'h10;
        start     = 1'b1;
        prev_done = 1'b0;
        bad_done  = 0;
        bad_diff  = 0;
        ndone     = 0;
        // Accept at the first edge; done seen after edges 9, 19, 29 counted from here
        for (int n = 1; n <= 32; n++) begin
            @(posedge clk);
            @(negedge clk);
            exp_done = (n == 9) || (n == 19) || (n == 29);
            if (done !== exp_done) bad_done++;
            if (done && prev_done) bad_done++;
            if (done) begin
                ndone++;
                if (diff !== 8'h10 || borrow_out !== 1'b0) bad_diff++;
            end
            prev_done = done;
        end
        start = 1'b0;
        checks++;
        if (bad_done !== 0 || ndone !== 3) begin
            errors++;
            $display("FAIL b2b_done_pattern: bad_cycles=%0d pulses=%0d required 0 3", bad_done, ndone);
        end
        checks++;
        if (bad_diff !== 0) begin
            errors++;
            $display("FAIL b2b_result: wrong results=%0d required 0 (diff=%h)", bad_diff, diff);
        end
        repeat (12) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: busy=%b required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_zero();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
